i2c_txn_scheduler: RTL and testbench

I2C_TXN_SCHEDULER -- requirements
Module: i2c_txn_scheduler

---
 rtl/i2c_txn_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_scheduler.sv
// ---------------------------------------------------------------------------
// i2c_txn_scheduler
//
// Shares one I2C byte controller among NREQ requesters. An owner is picked
// round-robin from IDLE; the owner then hands over byte-level commands
// ({start,stop,read,write}), which are forwarded to the byte controller and
// answered with a one-cycle response carrying the read data, the slave ACK,
// or an arbitration-loss / error flag. If the owner walks away while the bus
// is still claimed (a START went out without a STOP), a STOP is issued on its
// behalf before the bus is offered to anyone else.
//
// Ports
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   req_i[NREQ]                  bus ownership requests
//   cmd_valid_i / cmd_ready_o    per-requester command handshake
//   cmd_i[NREQ*4]                per-requester {start,stop,read,write}
//   txd_i[NREQ*8], ack_i[NREQ]   per-requester write byte / ACK to send
//   gnt_o[NREQ]                  one-hot owner, zero when idle
//   rsp_valid_o[NREQ]            completion pulse to the owner
//   rxd_o, rxack_o, al_o, err_o  completion payload
//   bc_*_o                       command to the byte controller
//   bc_cmd_ack_i, bc_dout_i,
//   bc_rxack_i, bc_al_i          status from the byte controller
//   busy_o                       scheduler is not idle
// ---------------------------------------------------------------------------
module i2c_txn_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   cmd_valid_i,
    input  logic [NREQ*4-1:0] cmd_i,
    input  logic [NREQ*8-1:0] txd_i,
    input  logic [NREQ-1:0]   ack_i,
    output logic [NREQ-1:0]   cmd_ready_o,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   rsp_valid_o,
    output logic [7:0]        rxd_o,
    output logic              rxack_o,
    output logic              al_o,
    output logic              err_o,
    output logic              bc_start_o,
    output logic              bc_stop_o,
    output logic              bc_read_o,
    output logic              bc_write_o,
    output logic              bc_ack_o,
    output logic [7:0]        bc_din_o,
    input  logic              bc_cmd_ack_i,
    input  logic [7:0]        bc_dout_i,
    input  logic              bc_rxack_i,
    input  logic              bc_al_i,
    output logic              busy_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [12:0] TO_LAST = 13'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            started_q, started_d;
    logic [12:0]     cnt_q, cnt_d;
    logic [3:0]      cmd_q, cmd_d;       // latched {start,stop,read,write}
    logic [3:0]      bc_q, bc_d;         // driven {start,stop,read,write}
    logic            bcack_q, bcack_d;
    logic [7:0]      din_q, din_d;
    logic [NREQ-1:0] rsp_q, rsp_d;
    logic [7:0]      rxd_q, rxd_d;
    logic            rxack_q, rxack_d;
    logic            al_q, al_d;
    logic            err_q, err_d;

    // Owner-side view of the per-requester buses
    logic       own_req, own_vld, own_ack;
    logic [3:0] own_cmd;
    logic [7:0] own_txd;

    always_comb begin
        own_req = 1'b0;
        own_vld = 1'b0;
        own_ack = 1'b0;
        own_cmd = 4'b0;
        own_txd = 8'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (own_q == IW'(i)) begin
                own_req = req_i[i];
                own_vld = cmd_valid_i[i];
                own_ack = ack_i[i];
                own_cmd = cmd_i[i*4 +: 4];
                own_txd = txd_i[i*8 +: 8];
            end
        end
    end

    // Round-robin search starting at ptr_q, wrapping at NREQ
    logic          sel_found;
    logic [IW-1:0] sel_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int            j;
            logic [IW-1:0] jj;
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IW'(j);
            if (!sel_found && req_i[jj]) begin
                sel_found = 1'b1;
                sel_idx   = jj;
            end
        end
    end

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) >= NREQ - 1) return '0;
        return i + 1'b1;
    endfunction

    // Exactly one of read/write (start/stop optional), or a bare stop
    function automatic logic cmd_legal(input logic [3:0] c);
        return (c[1] ^ c[0]) || (c == 4'b0100);
    endfunction

    logic hs;
    assign hs = (state_q == S_GRANT) && own_vld;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        own_d     = own_q;
        ptr_d     = ptr_q;
        started_d = started_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        bc_d      = bc_q;
        bcack_d   = bcack_q;
        din_d     = din_q;
        rsp_d     = '0;
        rxd_d     = rxd_q;
        rxack_d   = rxack_q;
        al_d      = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (sel_found) begin
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    own_d          = sel_idx;
                    state_d        = S_GRANT;
                end
            end

            S_GRANT: begin
                if (hs) begin
                    if (cmd_legal(own_cmd)) begin
                        cmd_d   = own_cmd;
                        bc_d    = own_cmd;
                        bcack_d = own_ack;
                        din_d   = own_txd;
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        rsp_d = gnt_q;
                        err_d = 1'b1;
                    end
                end else if (!own_req) begin
                    if (started_q) begin
                        // Bus still claimed: close it with a bare STOP first
                        bc_d    = 4'b0100;
                        bcack_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_RELEASE;
                    end else begin
                        gnt_d   = '0;
                        ptr_d   = next_idx(own_q);
                        state_d = S_IDLE;
                    end
                end
            end

            S_ISSUE: begin
                cnt_d = cnt_q + 13'd1;
                // Arbitration loss outranks a coincident done pulse
                if (bc_al_i) begin
                    bc_d      = '0;
                    bcack_d   = 1'b0;
                    rsp_d     = gnt_q;
                    al_d      = 1'b1;
                    started_d = 1'b0;
                    gnt_d     = '0;
                    ptr_d     = next_idx(own_q);
                    state_d   = S_IDLE;
                end else if (bc_cmd_ack_i) begin
                    bc_d    = '0;
                    bcack_d = 1'b0;
                    rsp_d   = gnt_q;
                    rxd_d   = bc_dout_i;
                    rxack_d = bc_rxack_i;
                    if (cmd_q[3]) started_d = 1'b1;
                    if (cmd_q[2]) started_d = 1'b0;
                    if (cmd_q[2]) begin
                        gnt_d   = '0;
                        ptr_d   = next_idx(own_q);
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GRANT;
                    end
                end else if (cnt_q == TO_LAST) begin
                    bc_d      = '0;
                    bcack_d   = 1'b0;
                    rsp_d     = gnt_q;
                    err_d     = 1'b1;
                    started_d = 1'b0;
                    gnt_d     = '0;
                    ptr_d     = next_idx(own_q);
                    state_d   = S_IDLE;
                end
            end

            S_RELEASE: begin
                cnt_d = cnt_q + 13'd1;
                // Silent cleanup: no response goes back to anyone
                if (bc_cmd_ack_i || (cnt_q == TO_LAST)) begin
                    bc_d      = '0;
                    bcack_d   = 1'b0;
                    started_d = 1'b0;
                    gnt_d     = '0;
                    ptr_d     = next_idx(own_q);
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                bc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            own_q     <= '0;
            ptr_q     <= '0;
            started_q <= 1'b0;
            cnt_q     <= '0;
            cmd_q     <= '0;
            bc_q      <= '0;
            bcack_q   <= 1'b0;
            din_q     <= '0;
            rsp_q     <= '0;
            rxd_q     <= '0;
            rxack_q   <= 1'b0;
            al_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            own_q     <= own_d;
            ptr_q     <= ptr_d;
            started_q <= started_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            bc_q      <= bc_d;
            bcack_q   <= bcack_d;
            din_q     <= din_d;
            rsp_q     <= rsp_d;
            rxd_q     <= rxd_d;
            rxack_q   <= rxack_d;
            al_q      <= al_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready_o = (state_q == S_GRANT) ? gnt_q : '0;
    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_q;
    assign rxd_o       = rxd_q;
    assign rxack_o     = rxack_q;
    assign al_o        = al_q;
    assign err_o       = err_q;
    assign bc_start_o  = bc_q[3];
    assign bc_stop_o   = bc_q[2];
    assign bc_read_o   = bc_q[1];
    assign bc_write_o  = bc_q[0];
    assign bc_ack_o    = bcack_q;
    assign bc_din_o    = din_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
module tb_i2c_txn_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0, cval = '0, ackv = '0;
    logic [15:0] cmd = '0;
    logic [31:0] txd = '0;
    logic        bc_ack = 1'b0, bc_rxack = 1'b0, bc_al = 1'b0;
    logic [7:0]  bc_dout = '0;

    logic [3:0]  cmd_ready, gnt, rsp;
    logic [7:0]  rxd, bdin;
    logic        rxack, al, err, bs, bp, br, bw, bk, busy;
    logic [3:0]  bcbits;

    int total = 0;
    int bad   = 0;

    assign bcbits = {bs, bp, br, bw};

    i2c_txn_scheduler #(.NREQ(N), .TIMEOUT(TO)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .req_i        (req),
        .cmd_valid_i  (cval),
        .cmd_i        (cmd),
        .txd_i        (txd),
        .ack_i        (ackv),
        .cmd_ready_o  (cmd_ready),
        .gnt_o        (gnt),
        .rsp_valid_o  (rsp),
        .rxd_o        (rxd),
        .rxack_o      (rxack),
        .al_o         (al),
        .err_o        (err),
        .bc_start_o   (bs),
        .bc_stop_o    (bp),
        .bc_read_o    (br),
        .bc_write_o   (bw),
        .bc_ack_o     (bk),
        .bc_din_o     (bdin),
        .bc_cmd_ack_i (bc_ack),
        .bc_dout_i    (bc_dout),
        .bc_rxack_i   (bc_rxack),
        .bc_al_i      (bc_al),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] cmd;
        logic [7:0] txd;
        logic       ackv;
        logic [7:0] dout;
        logic       rxack;
        logic       legal;      // expected: forwarded to byte controller
        logic       busy_after; // expected busy_o after completion
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        req = '0; cval = '0; cmd = '0; txd = '0; ackv = '0;
        bc_ack = 1'b0; bc_dout = '0; bc_rxack = 1'b0; bc_al = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present one command from requester r for exactly one edge
    task automatic issue(input int r, input logic [3:0] c, input logic [7:0] d,
                         input logic a, input logic [3:0] noise);
        cmd  = 16'(c) << (r * 4);
        txd  = 32'(d) << (r * 8);
        ackv = 4'(a) << r;
        cval = noise | (4'b0001 << r);
        tick();
        cval = '0;
    endtask

    task automatic complete(input logic [7:0] dout, input logic rx);
        bc_ack = 1'b1; bc_dout = dout; bc_rxack = rx;
        tick();
        bc_ack = 1'b0;
    endtask

    function automatic logic legal_ref(input logic [3:0] c);
        int n_rw;
        n_rw = int'(c[1]) + int'(c[0]);
        return (n_rw == 1) || (c == 4'b0100);
    endfunction

    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            logic [1:0] ix;
            ix = 2'((p + k) % N);
            if (m[ix]) return (p + k) % N;
        end
        return 0;
    endfunction

    // Random-phase model state
    int         m_ptr, m_owner, act, oc, dl;
    logic       m_started, m_grant;
    logic [3:0] own_bit, rc, rmask;
    logic [7:0] rd, rdo;
    logic       ra, rrx;

    initial begin
        //            cmd      txd    ack  dout   rxa  legal busy
        vecs[0]  = '{4'b1001, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{4'b0001, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{4'b0101, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{4'b1110, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'b0010, 8'h00, 1'b0, 8'h81, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{4'b0100, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{4'b1111, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{4'b0011, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{4'b0000, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{4'b1000, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{4'b1100, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{4'b1010, 8'h00, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b1};

        // Reset state
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp", 32'(rsp), 32'h0);
        chk("rst_bc", 32'({bcbits, bk}), 32'h0);
        chk("rst_din", 32'(bdin), 32'h0);
        chk("rst_flags", 32'({rxd, rxack, al, err}), 32'h0);

        // Table-driven command legality and completion
        for (int v = 0; v < 12; v++) begin
            do_reset();
            req = 4'b0010;
            tick();
            chk("tbl_gnt", 32'(gnt), 32'h2);
            issue(1, vecs[v].cmd, vecs[v].txd, vecs[v].ackv, 4'b0000);
            if (vecs[v].legal) begin
                chk("tbl_bc", 32'(bcbits), 32'(vecs[v].cmd));
                chk("tbl_din", 32'(bdin), 32'(vecs[v].txd));
                chk("tbl_bcack", 32'(bk), 32'(vecs[v].ackv));
                chk("tbl_norsp", 32'(rsp), 32'h0);
                complete(vecs[v].dout, vecs[v].rxack);
                chk("tbl_rsp", 32'(rsp), 32'h2);
                chk("tbl_rxd", 32'(rxd), 32'(vecs[v].dout));
                chk("tbl_rxack", 32'(rxack), 32'(vecs[v].rxack));
                chk("tbl_flags", 32'({al, err}), 32'h0);
                chk("tbl_bc_clr", 32'(bcbits), 32'h0);
            end else begin
                chk("tbl_err_rsp", 32'(rsp), 32'h2);
                chk("tbl_err", 32'(err), 32'h1);
                chk("tbl_err_bc", 32'(bcbits), 32'h0);
            end
            chk("tbl_busy", 32'(busy), 32'(vecs[v].busy_after));
        end

        // Two-command transaction then round-robin hand-over
        do_reset();
        req = 4'b0101;
        tick();
        chk("s1_gnt0", 32'(gnt), 32'h1);
        chk("s1_ready", 32'(cmd_ready), 32'h1);
        issue(0, 4'b1001, 8'hA0, 1'b0, 4'b0000);
        chk("s1_bc1", 32'(bcbits), 32'h9);
        chk("s1_din1", 32'(bdin), 32'hA0);
        complete(8'h00, 1'b1);
        chk("s1_rsp1", 32'(rsp), 32'h1);
        chk("s1_rxack1", 32'(rxack), 32'h1);
        issue(0, 4'b0101, 8'h55, 1'b0, 4'b0000);
        chk("s1_bc2", 32'(bcbits), 32'h5);
        chk("s1_din2", 32'(bdin), 32'h55);
        complete(8'h00, 1'b0);
        chk("s1_rsp2", 32'(rsp), 32'h1);
        chk("s1_rxack2", 32'(rxack), 32'h0);
        chk("s1_gnt_idle", 32'(gnt), 32'h0);
        tick();
        chk("s1_rsp_pulse", 32'(rsp), 32'h0);
        tick();
        chk("s1_gnt2", 32'(gnt), 32'h4);

        // Read with ACK
        issue(2, 4'b0010, 8'h00, 1'b1, 4'b0000);
        chk("s2_read", 32'({br, bk}), 32'h3);
        tick();
        chk("s2_hold", 32'({br, bk}), 32'h3);
        complete(8'h3C, 1'b0);
        chk("s2_rsp", 32'(rsp), 32'h4);
        chk("s2_rxd", 32'(rxd), 32'h3C);
        chk("s2_clr", 32'({bcbits, bk}), 32'h0);
        tick();
        chk("s2_pulse", 32'(rsp), 32'h0);

        // Timeout
        issue(2, 4'b0001, 8'h11, 1'b0, 4'b0000);
        repeat (TO - 1) tick();
        chk("s3_early", 32'(rsp), 32'h0);
        chk("s3_held", 32'(bw), 32'h1);
        tick();
        chk("s3_rsp", 32'(rsp), 32'h4);
        chk("s3_err", 32'(err), 32'h1);
        chk("s3_busy", 32'(busy), 32'h0);
        chk("s3_bc", 32'(bcbits), 32'h0);
        tick();
        chk("s3_regnt", 32'(gnt), 32'h1);

        // Arbitration loss, coincident with done
        issue(0, 4'b1001, 8'h77, 1'b0, 4'b0000);
        bc_al = 1'b1; bc_ack = 1'b1;
        tick();
        bc_al = 1'b0; bc_ack = 1'b0;
        chk("s4_rsp", 32'(rsp), 32'h1);
        chk("s4_al", 32'({al, err}), 32'h2);
        chk("s4_gnt", 32'(gnt), 32'h0);
        chk("s4_bc", 32'(bcbits), 32'h0);
        tick();
        chk("s4_next", 32'(gnt), 32'h4);

        // Owner leaves with the bus claimed
        issue(2, 4'b1001, 8'h5A, 1'b0, 4'b0000);
        complete(8'h00, 1'b0);
        req = 4'b0001;
        tick();
        chk("s5_stop", 32'(bcbits), 32'h4);
        chk("s5_busy", 32'(busy), 32'h1);
        chk("s5_norsp", 32'(rsp), 32'h0);
        complete(8'h00, 1'b0);
        chk("s5_norsp2", 32'(rsp), 32'h0);
        chk("s5_idle", 32'(busy), 32'h0);
        chk("s5_stop_clr", 32'(bp), 32'h0);
        tick();
        chk("s5_regnt", 32'(gnt), 32'h1);

        // Illegal read+write
        issue(0, 4'b1111, 8'hFF, 1'b1, 4'b0000);
        chk("s6_rsp", 32'(rsp), 32'h1);
        chk("s6_err", 32'(err), 32'h1);
        chk("s6_bc", 32'({bcbits, bk}), 32'h0);
        chk("s6_gnt", 32'(gnt), 32'h1);
        chk("s6_ready", 32'(cmd_ready), 32'h1);

        // Reset in the middle of a transfer
        issue(0, 4'b0001, 8'h42, 1'b0, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s7_busy", 32'(busy), 32'h0);
        chk("s7_gnt", 32'(gnt), 32'h0);
        chk("s7_bc", 32'(bcbits), 32'h0);

        // Randomized transactions against a transaction-level model
        do_reset();
        m_ptr = 0; m_started = 1'b0; m_grant = 1'b0; m_owner = 0;
        for (int ep = 0; ep < 200; ep++) begin
            if (!m_grant) begin
                rmask = 4'($urandom_range(1, 15));
                req = rmask;
                tick();
                m_owner = rr_pick(rmask, m_ptr);
                own_bit = 4'b0001 << m_owner;
                chk("rnd_gnt", 32'(gnt), 32'(own_bit));
                m_grant = 1'b1;
            end else begin
                act = $urandom_range(0, 9);
                if (act == 0) begin
                    req = '0;
                    tick();
                    if (m_started) begin
                        chk("rnd_rel_stop", 32'(bcbits), 32'h4);
                        chk("rnd_rel_busy", 32'(busy), 32'h1);
                        dl = $urandom_range(0, 3);
                        repeat (dl) tick();
                        complete(8'h00, 1'b0);
                        chk("rnd_rel_norsp", 32'(rsp), 32'h0);
                        chk("rnd_rel_idle", 32'(busy), 32'h0);
                    end else begin
                        chk("rnd_drop_idle", 32'({gnt, busy}), 32'h0);
                    end
                    m_started = 1'b0;
                    m_ptr = (m_owner + 1) % N;
                    m_grant = 1'b0;
                end else begin
                    rc = 4'($urandom);
                    rd = 8'($urandom);
                    ra = 1'($urandom);
                    req = 4'($urandom) | own_bit;
                    issue(m_owner, rc, rd, ra, 4'($urandom));
                    if (!legal_ref(rc)) begin
                        chk("rnd_ill_rsp", 32'(rsp), 32'(own_bit));
                        chk("rnd_ill_err", 32'({bcbits, err}), 32'h1);
                    end else begin
                        chk("rnd_bc", 32'({bcbits, bk, bdin}), 32'({rc, ra, rd}));
                        oc = $urandom_range(0, 11);
                        if (oc == 0) begin
                            repeat (TO - 1) tick();
                            chk("rnd_to_early", 32'(rsp), 32'h0);
                            tick();
                            chk("rnd_to", 32'({rsp, err, al, busy}), 32'({own_bit, 3'b100}));
                            m_started = 1'b0;
                            m_ptr = (m_owner + 1) % N;
                            m_grant = 1'b0;
                            req = '0;
                        end else if (oc <= 2) begin
                            dl = $urandom_range(0, 4);
                            repeat (dl) tick();
                            bc_al = 1'b1;
                            bc_ack = 1'($urandom);
                            tick();
                            bc_al = 1'b0; bc_ack = 1'b0;
                            chk("rnd_al", 32'({rsp, al, err, busy}), 32'({own_bit, 3'b100}));
                            m_started = 1'b0;
                            m_ptr = (m_owner + 1) % N;
                            m_grant = 1'b0;
                            req = '0;
                        end else begin
                            dl = $urandom_range(0, 5);
                            repeat (dl) tick();
                            chk("rnd_hold", 32'(bcbits), 32'(rc));
                            rdo = 8'($urandom);
                            rrx = 1'($urandom);
                            complete(rdo, rrx);
                            chk("rnd_done", 32'({rsp, rxd, rxack, al, err}), 32'({own_bit, rdo, rrx, 2'b00}));
                            if (rc[3]) m_started = 1'b1;
                            if (rc[2]) begin
                                m_started = 1'b0;
                                chk("rnd_stop_idle", 32'({gnt, busy}), 32'h0);
                                m_ptr = (m_owner + 1) % N;
                                m_grant = 1'b0;
                                req = '0;
                            end else begin
                                chk("rnd_keep", 32'({gnt, busy}), 32'({own_bit, 1'b1}));
                            end
                        end
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
